// File: rtl/secuenciador_suma_multibyte.sv
// Byte-serial wide adder: one 8-bit adder walked over NBYTES slices, LSB first, carry chained.
// Optional build macro SECUENCIADOR_RESTA_EN adds a `resta` input (A - B via inverted B, carry-in 1).

module sumador_8bits_1 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Carry,
  output logic       Ovf
);
  assign {Carry, S} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};
  assign Ovf        = (A[7] == B[7]) && (S[7] != A[7]);
endmodule

module secuenciador_suma_multibyte #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] A,
  input  logic [8*NBYTES-1:0] B,
  input  logic                Cin,
`ifdef SECUENCIADOR_RESTA_EN
  input  logic                resta,
`endif
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] S,
  output logic                Carry,
  output logic                Ovf
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, SUMA, FIN} state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  a_q, b_q, s_q, s_d;
  logic          cy_q, cy_d, carry_q, ovf_q, busy_q, done_q;
  logic [W-1:0]  a_sh, b_sh;
  logic [7:0]    a_sl, b_sl, add_s;
  logic          add_c, add_o;
  logic          last;

`ifdef SECUENCIADOR_RESTA_EN
  logic resta_q;
  assign cy_d = resta ? 1'b1 : Cin;
  assign b_sl = b_sh[7:0] ^ {8{resta_q}};
`else
  assign cy_d = Cin;
  assign b_sl = b_sh[7:0];
`endif

  assign a_sh = a_q >> {idx_q, 3'b000};
  assign b_sh = b_q >> {idx_q, 3'b000};
  assign a_sl = a_sh[7:0];
  assign last = (idx_q == IW'(NBYTES - 1));

  sumador_8bits_1 u_add (
    .A(a_sl), .B(b_sl), .Cin(cy_q), .S(add_s), .Carry(add_c), .Ovf(add_o)
  );

  // Only the slice selected by idx is replaced; other bytes keep stale data until written.
  always_comb begin
    s_d = s_q;
    for (int i = 0; i < NBYTES; i++)
      if (idx_q == IW'(i)) s_d[8*i +: 8] = add_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      s_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SECUENCIADOR_RESTA_EN
      resta_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            cy_q    <= cy_d;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SUMA;
`ifdef SECUENCIADOR_RESTA_EN
            resta_q <= resta;
`endif
          end
        end
        SUMA: begin
          s_q  <= s_d;
          cy_q <= add_c;
          if (last) begin
            carry_q <= add_c;
            ovf_q   <= add_o;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign Carry = carry_q;
  assign Ovf   = ovf_q;
endmodule

// File: tb/tb_secuenciador_suma_multibyte.sv
// Randomized bench for secuenciador_suma_multibyte with a cycle-count reference model plus literal vectors.
module tb_secuenciador_suma_multibyte;
  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic Cin = 1'b0;
  logic resta_v = 1'b0;
  logic busy, done, Carry, Ovf;
  logic [W-1:0] S;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  secuenciador_suma_multibyte #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
`ifdef SECUENCIADOR_RESTA_EN
    .resta(resta_v),
`endif
    .busy(busy), .done(done), .S(S), .Carry(Carry), .Ovf(Ovf)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, carry, sum} of the whole-width operation.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic r);
    logic [W:0] t;
    logic [W-1:0] bb;
    logic c0, o;
    bb = b;
    c0 = cin;
`ifdef SECUENCIADOR_RESTA_EN
    if (r) begin bb = ~b; c0 = 1'b1; end
`endif
    t = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    o = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return {o, t};
  endfunction

  // Model: an accepted op keeps busy for NBYTES cycles, then one done cycle, then idle.
  int mcnt;
  logic [W-1:0] mS;
  logic mC, mO;
  logic [W+1:0] pend;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 0; mS <= '0; mC <= 1'b0; mO <= 1'b0;
    end else if (mcnt == 0) begin
      if (start) begin
        mcnt <= 1;
        pend <= ref_op(A, B, Cin, resta_v);
      end
    end else if (mcnt == NBYTES + 1) begin
      mcnt <= 0;
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt == NBYTES) begin
        mS <= pend[W-1:0]; mC <= pend[W]; mO <= pend[W+1];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, (mcnt >= 1 && mcnt <= NBYTES));
      chk("done", done, (mcnt == NBYTES + 1));
      chk("busy_done_excl", busy & done, 1'b0);
      if (!(mcnt >= 1 && mcnt <= NBYTES)) begin
        chk("S", S, mS);
        chk("Carry", Carry, mC);
        chk("Ovf", Ovf, mO);
      end
    end
  end

  // Single operation with literal expectations, latency and busy-length checks.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic r, input logic [W-1:0] es, input logic ec, input logic eo);
    int lat, nbusy;
    bit got;
    @(negedge clk);
    A = a; B = b; Cin = cin; resta_v = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom; Cin = $urandom;
    lat = 0; nbusy = 0; got = 1'b0;
    while (!got && lat < 20) begin
      if (busy) nbusy++;
      if (done) got = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    chk("done_seen", got, 1'b1);
    chk("latency", lat, NBYTES);
    chk("busy_cycles", nbusy, NBYTES);
    chk("lit_S", S, es);
    chk("lit_Carry", Carry, ec);
    chk("lit_Ovf", Ovf, eo);
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: begin v = '0; v[W-1] = 1'b1; end
      3: begin v = '1; v[W-1] = 1'b0; end
      default: for (int i = 0; i < NBYTES; i++) v[8*i +: 8] = 8'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int ndone;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_S", S, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    cmp_en = 1'b1;
    rst = 1'b0;

    do_op(32'h0000000A, 32'h00000005, 1'b0, 1'b0, 32'h0000000F, 1'b0, 1'b0);
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    do_op(32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);

    // Start pulses while busy must be ignored.
    @(negedge clk);
    A = 32'h01020304; B = 32'h10203040; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 32'hDEADBEEF; B = 32'hCAFEF00D; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    A = 32'h55555555; B = 32'hAAAAAAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (8) begin
      if (done) begin
        ndone++;
        chk("ign_S", S, 32'h11223344);
      end
      @(negedge clk);
    end
    chk("ign_done_count", ndone, 1);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_S", S, '0);
    chk("arst_Carry", Carry, 1'b0);
    chk("arst_Ovf", Ovf, 1'b0);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin @(negedge clk); if (done) ndone++; end
    chk("arst_no_done", ndone, 0);
    do_op(32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b0);

`ifdef SECUENCIADOR_RESTA_EN
    do_op(32'h00000005, 32'h0000000A, 1'b0, 1'b1, 32'hFFFFFFFB, 1'b0, 1'b0);
    do_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
`endif

    // Random traffic: operands and start change every cycle, including while busy.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      A = rnd_op(); B = rnd_op(); Cin = $urandom;
`ifdef SECUENCIADOR_RESTA_EN
      resta_v = $urandom;
`endif
    end
    @(negedge clk);
    start = 1'b0;
    repeat (NBYTES + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
